// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the dmem port arbiter (build option: DMEM_ARB_RR_EN).
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W   = 12;
    localparam int DMEM_DATA_W   = 32;
    localparam int DMEM_MAX_WAIT = 4;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_K = 1'b1
    } owner_t;

    typedef struct packed {
        logic                   req;
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } acc_req_t;

    function automatic owner_t other_port(input owner_t o);
        if (o == OWN_C) begin
            return OWN_K;
        end else begin
            return OWN_C;
        end
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the CPU (C) and PS/2 capture (K) requesters.
// prefer_k breaks ties; it carries either the starvation promotion or the round-robin turn.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic c_req,
    input  logic k_req,
    input  logic prefer_k,
    output logic valid,
    output logic pick_k
);

    // Single winner per cycle; the tie-break only matters when both ask
    always_comb begin
        valid  = c_req | k_req;
        pick_k = 1'b0;
        if (c_req && k_req) begin
            pick_k = prefer_k;
        end else if (k_req) begin
            pick_k = 1'b1;
        end else begin
            pick_k = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port synchronous dmem between the CPU (C) and PS/2 capture (K) ports.
// Build option: define DMEM_ARB_RR_EN for round-robin; otherwise fixed C priority with K promotion.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    input  logic              k_req,
    input  logic              k_we,
    input  logic [ADDR_W-1:0] k_addr,
    input  logic [DATA_W-1:0] k_wdata,
    output logic              k_gnt,
    output logic              k_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_wren,
    input  logic [DATA_W-1:0] dmem_q,
    output logic [ADDR_W-1:0] debug_addr,
    output logic [DATA_W-1:0] debug_data
);

    logic   c_req_s;
    logic   k_req_s;
    logic   prefer_k_s;
    logic   pick_valid_s;
    logic   pick_k_s;
    owner_t win_owner_s;
    logic   win_we_s;
    logic   rd_pend_q;
    logic   rd_pend_d;
    owner_t rd_owner_q;
    owner_t rd_owner_d;

    // Requests are masked while reset is high so no grant leaves a reset cycle
    always_comb begin
        c_req_s = c_req & ~reset;
        k_req_s = k_req & ~reset;
    end

`ifdef DMEM_ARB_RR_EN
    owner_t rr_last_q;
    owner_t rr_last_d;

    // On a tie the port that did not win last time gets the slot
    always_comb begin
        prefer_k_s = (other_port(rr_last_q) == OWN_K);
    end

    // Remember the most recent winner
    always_comb begin
        rr_last_d = rr_last_q;
        if (pick_valid_s) begin
            rr_last_d = win_owner_s;
        end else begin
            rr_last_d = rr_last_q;
        end
    end

    // Round-robin history register
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_q <= OWN_C;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;

    // K is promoted over C once it has been refused MAX_WAIT cycles in a row
    always_comb begin
        prefer_k_s = (wait_cnt_q == WAIT_SAT);
    end

    // Count consecutive refusals of K, saturating; any grant or drop restarts it
    always_comb begin
        wait_cnt_d = {WAIT_W{1'b0}};
        if (k_req_s && !k_gnt) begin
            if (wait_cnt_q == WAIT_SAT) begin
                wait_cnt_d = WAIT_SAT;
            end else begin
                wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            wait_cnt_d = {WAIT_W{1'b0}};
        end
    end

    // Starvation counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= {WAIT_W{1'b0}};
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    dmem_arb_pick u_pick (
        .c_req    (c_req_s),
        .k_req    (k_req_s),
        .prefer_k (prefer_k_s),
        .valid    (pick_valid_s),
        .pick_k   (pick_k_s)
    );

    // Steer the winner onto the dmem port; an idle cycle parks address and data at zero
    always_comb begin
        c_gnt       = 1'b0;
        k_gnt       = 1'b0;
        win_owner_s = OWN_C;
        win_we_s    = 1'b0;
        dmem_addr   = {ADDR_W{1'b0}};
        dmem_wdata  = {DATA_W{1'b0}};
        if (pick_valid_s && pick_k_s) begin
            k_gnt       = 1'b1;
            win_owner_s = OWN_K;
            win_we_s    = k_we;
            dmem_addr   = k_addr;
            dmem_wdata  = k_wdata;
        end else if (pick_valid_s) begin
            c_gnt       = 1'b1;
            win_owner_s = OWN_C;
            win_we_s    = c_we;
            dmem_addr   = c_addr;
            dmem_wdata  = c_wdata;
        end else begin
            win_owner_s = OWN_C;
        end
        dmem_wren  = pick_valid_s & win_we_s;
        debug_addr = dmem_addr;
        debug_data = dmem_wdata;
    end

    // Tag each granted read with its owner so the return one cycle later is routed back
    always_comb begin
        rd_pend_d = pick_valid_s & ~win_we_s;
        if (pick_valid_s) begin
            rd_owner_d = win_owner_s;
        end else begin
            rd_owner_d = rd_owner_q;
        end
    end

    // Read-return tracking registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_C;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // A reset arriving while a read is in flight swallows its return
    always_comb begin
        c_rvalid = rd_pend_q & ~reset & (rd_owner_q == OWN_C);
        k_rvalid = rd_pend_q & ~reset & (rd_owner_q == OWN_K);
        rdata    = dmem_q;
    end

endmodule
